// File: rtl/lsi_vic_pkg.sv
// Shared types and constants for the LSI-11 vectored interrupt controller.
package lsi_vic_pkg;

  localparam int unsigned MaxSrc = 16;
  localparam int unsigned VecW   = 16;

  localparam logic [VecW-1:0] VecSpurDflt = 16'o000074;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StAck,
    StSpur,
    StWdrop
  } vic_state_e;

endpackage

// File: rtl/lsi_vic_if.sv
// Interrupt-acknowledge vector handshake between the LSI-11 core and the VIC.
interface lsi_vic_if;
  import lsi_vic_pkg::*;

  logic            wbi_stb_i;
  logic            wbi_ack_o;
  logic [VecW-1:0] wbi_dat_o;

  modport master (output wbi_stb_i, input wbi_ack_o, input wbi_dat_o);
  modport slave  (input wbi_stb_i, output wbi_ack_o, output wbi_dat_o);

endinterface

// File: rtl/lsi_vic_prio.sv
// Fixed-priority encoder: lowest asserted request index wins.
module lsi_vic_prio #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] idx_o,
  output logic            vld_o
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IdxW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsi_vic.sv
// Vectored interrupt controller for the LSI-11 interrupt-acknowledge port.
// Optional: define LSI_VIC_SPURIOUS_EN to answer spurious strobes with VEC_SPUR.
module lsi_vic
  import lsi_vic_pkg::*;
#(
  parameter int unsigned     N        = 8,
  parameter logic [VecW-1:0] VEC_SPUR = VecSpurDflt
) (
  input  logic              vm_clk_p,
  input  logic              vm_rst_n,
  input  logic [N-1:0]      irq_i,
  input  logic [VecW*N-1:0] vec_i,
  output logic [N-1:0]      iack_o,
  output logic              vm_virq,
  lsi_vic_if.slave          wbi
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  if (N < 1 || N > MaxSrc || VEC_SPUR[1:0] != 2'b00) begin : gen_bad_cfg
    $error("lsi_vic: N out of range or VEC_SPUR not word aligned");
  end

  vic_state_e      state_q, state_d;
  logic [IdxW-1:0] win_idx_q, win_idx_d, prio_idx;
  logic            win_vld_q, win_vld_d, prio_vld;
  logic            virq_q, ack_q, ack_d;
  logic [N-1:0]    iack_q, iack_d;
  logic [VecW-1:0] dat_q, dat_d, vec_sel;

  lsi_vic_prio #(
    .N    (N),
    .IdxW (IdxW)
  ) u_prio (
    .req_i (irq_i),
    .idx_o (prio_idx),
    .vld_o (prio_vld)
  );

  always_comb begin
    vec_sel = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (win_idx_q == IdxW'(k)) vec_sel = vec_i[k*VecW +: VecW];
    end
  end

  always_comb begin
    state_d   = state_q;
    win_idx_d = win_idx_q;
    win_vld_d = win_vld_q;
    ack_d     = 1'b0;
    iack_d    = '0;
    dat_d     = dat_q;
    unique case (state_q)
      StIdle: if (wbi.wbi_stb_i) state_d = StArb;
      StArb: begin
        win_idx_d = prio_idx;
        win_vld_d = prio_vld;
        state_d   = prio_vld ? StAck : StSpur;
      end
      StAck: begin
        ack_d = 1'b1;
        for (int k = 0; k < int'(N); k++) begin
          iack_d[k] = win_vld_q && (win_idx_q == IdxW'(k));
        end
        dat_d   = vec_sel & ~VecW'(3);
        state_d = StWdrop;
      end
      StSpur: begin
`ifdef LSI_VIC_SPURIOUS_EN
        ack_d = 1'b1;
        dat_d = VEC_SPUR;
`endif
        state_d = StWdrop;
      end
      // One vector per strobe: hold here until the core releases it.
      StWdrop: if (!wbi.wbi_stb_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
    if (!vm_rst_n) begin
      state_q   <= StIdle;
      win_idx_q <= '0;
      win_vld_q <= 1'b0;
      virq_q    <= 1'b0;
      ack_q     <= 1'b0;
      iack_q    <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      win_idx_q <= win_idx_d;
      win_vld_q <= win_vld_d;
      virq_q    <= |irq_i;
      ack_q     <= ack_d;
      iack_q    <= iack_d;
      dat_q     <= dat_d;
    end
  end

  assign vm_virq       = virq_q;
  assign iack_o        = iack_q;
  assign wbi.wbi_ack_o = ack_q;
  assign wbi.wbi_dat_o = dat_q;

endmodule

// File: doc/lsi_vic.md
Name: lsi_vic

Overview:
- Vectored interrupt controller on the interrupt-acknowledge port of the Wishbone LSI-11 core.
- Collects level interrupt requests from up to N peripherals and drives the core's vm_virq input.
- On each core interrupt-acknowledge strobe, selects the highest-priority pending source (fixed daisy-chain order) and returns that source's vector on the wbi_* handshake.
- Sends a one-cycle acknowledge pulse to the selected device so it can drop its request.

Parameters:
- N, 8, number of interrupt sources, 1..16; index 0 is highest priority.
- VEC_SPUR, 16'o000074, vector returned for a spurious acknowledge (used only with LSI_VIC_SPURIOUS_EN).

Ports:
- vm_clk_p  in  1  core positive clock; all logic on its rising edge.
- vm_rst_n  in  1  asynchronous active-low reset.
- irq_i  in  N  level interrupt requests, one per device; synchronous to vm_clk_p.
- vec_i  in  16*N  per-device vectors; source k occupies bits [16k+15:16k]; bits [1:0] ignored and forced to 0.
- iack_o  out  N  one-hot, one-cycle acknowledge pulse to the selected device.
- vm_virq  out  1  registered interrupt request to the core.
- wbi_stb_i  in  1  interrupt vector strobe from the core.
- wbi_ack_o  out  1  interrupt vector acknowledge, one-cycle pulse.
- wbi_dat_o  out  16  vector to the core; valid in the wbi_ack_o cycle and held afterwards.

Behaviour:
- Reset (vm_rst_n=0, asynchronous): vm_virq=0, wbi_ack_o=0, iack_o=0, wbi_dat_o=0, state=IDLE, winner register cleared.
- Reset mid-handshake aborts the transaction. No ack is produced. After release the FSM is in IDLE, and the core's bus timer handles its pending strobe.
- vm_virq: registered copy of |irq_i. One cycle latency. Not masked by FSM state.
- Arbitration: lowest asserted index in irq_i wins. Computed combinationally, captured only in state ARB.
- FSM:
  - IDLE: wbi_stb_i=1 -> ARB.
  - ARB: capture winner index and valid flag from the current irq_i.
    - Valid -> ACK.
    - Not valid -> SPUR.
  - ACK: for one cycle, wbi_ack_o=1, iack_o[winner]=1, wbi_dat_o={vec_i[winner][15:2],2'b00}. -> WDROP.
  - SPUR:
    - With the feature: behave like ACK, with wbi_dat_o=VEC_SPUR and iack_o=0.
    - Without the feature: no outputs driven; -> WDROP. The core's Q-bus timeout then aborts the cycle.
  - WDROP: wait for wbi_stb_i=0 -> IDLE. This guarantees one vector per strobe even if the strobe is held.
- Latency: strobe seen high at edge t -> wbi_ack_o high for the cycle following edge t+2. Exactly one ack per strobe assertion.
- Request dropped between ARB and ACK: the captured winner is still acknowledged, because the vector was sampled at the ACK cycle from vec_i of the winner. Devices must hold vec_i stable while irq_i is asserted and until iack_o.
- A new higher-priority request arriving after ARB does not preempt the current acknowledge. It wins the next strobe.
- Simultaneous requests: exactly one iack_o bit per transaction, and the other requests stay pending.
- wbi_dat_o holds its last value outside the ack cycle. The core samples it only with ack.
- irq_i bits at index >= N do not exist. No width-extension rules beyond the index math: the winner index is $clog2(N) bits, minimum 1.

Optional Feature:
- LSI_VIC_SPURIOUS_EN defined: a strobe with no pending request is answered with VEC_SPUR in the normal ack timing, so the core traps through the spurious vector.
- Undefined: no ack for a spurious strobe. The core's bus-timeout/berr path handles it. VEC_SPUR is unused.

Decomposition:
- Package lsi_vic_pkg:
  - FSM state encoding IDLE/ARB/ACK/SPUR/WDROP.
  - Max source count 16.
  - Default spurious vector 16'o000074.
  - Vector width 16.
- One sub-module, lsi_vic_prio: purely combinational fixed-priority encoder (N-bit request in, index and valid out). Reused for the winner select.

Test Plan:
- Reset, then irq_i=8'b00000100, vec_i[2]=16'o000060 -> vm_virq=1 one cycle later. Pulse wbi_stb_i -> ack two cycles after stb sampled, wbi_dat_o=16'o000060, iack_o=8'b00000100 for exactly one cycle.
- irq_i=8'b10010010, vectors 0o100/0o110/0o120 on sources 1/4/7. Three strobes, each device dropping its request on its iack -> vectors returned 0o100, 0o110, 0o120 in that order. vm_virq=0 after the third.
- wbi_stb_i held high for 10 cycles with irq_i=8'b00000001 -> exactly one wbi_ack_o and one iack_o[0]. FSM returns to IDLE only after stb falls.
- Strobe with irq_i=0:
  - Feature on: ack with 16'o000074, iack_o=0.
  - Feature off: no ack within 64 cycles; FSM returns to IDLE when stb drops.
- vec_i[3]=16'o000063 with irq_i[3]=1 -> returned vector 16'o000060 (low bits forced to zero).
- Assert vm_rst_n=0 during ACK state -> wbi_ack_o, iack_o, vm_virq immediately 0. After release with stb low, state is IDLE and the next strobe is served normally.
